execute_issue_scheduler: RTL
============================

# execute_issue_scheduler

Issue scheduler for the execute stage: decides each cycle whether the instruction at the execute input may issue, given its source operands and the long-latency results still in flight. It keeps a scoreboard of pending long-latency destinations (general and system registers) and an outstanding-operation counter. It also registers the current writeback into the one-cycle-delayed "previous writeback" bus that the execute forwarding unit consumes. It sits between decode/dispatch and the execute forwarding/ALU datapath.

## Interface
- P_MAX_OUTSTANDING, 4, maximum concurrently pending long-latency ops (1..15)
- iCLOCK  in  1  clock; all state on rising edge
- iRESET_SYNC  in  1  synchronous, active-high reset
- iFLUSH  in  1  discard all pending scoreboard state (pipeline flush)
- iPREV_VALID  in  1  instruction present at execute input
- iPREV_SRC0_POINTER / iPREV_SRC1_POINTER  in  5  source register numbers
- iPREV_SRC0_SYSREG / iPREV_SRC1_SYSREG  in  1  source is a system register
- iPREV_SRC0_IMM / iPREV_SRC1_IMM  in  1  source is an immediate; never hazards
- iPREV_DEST_VALID  in  1  instruction writes a register
- iPREV_DEST  in  5  destination number
- iPREV_DEST_SYSREG  in  1  destination is a system register
- iPREV_LONG  in  1  result comes back via iLONG_DONE_* (load, divide)
- oPREV_BUSY  out  1  stall; input instruction held
- oNEXT_VALID  out  1  instruction issues this cycle
- iNEXT_BUSY  in  1  downstream cannot accept
- iLONG_DONE_VALID  in  1  a long op completes; its writeback is on iWB_* this cycle
- iLONG_DONE_DEST  in  5, iLONG_DONE_SYSREG  in  1  completing destination
- iWB_GR_VALID  in  1, iWB_GR_DATA  in  32, iWB_GR_DEST  in  5, iWB_GR_DEST_SYSREG  in  1, iWB_SPR_VALID  in  1, iWB_SPR_DATA  in  32: current writeback
- oPREV_WB_GR_VALID  out  1, oPREV_WB_GR_DATA  out  32, oPREV_WB_GR_DEST  out  5, oPREV_WB_GR_DEST_SYSREG  out  1, oPREV_WB_SPR_VALID  out  1, oPREV_WB_SPR_DATA  out  32: writeback delayed one cycle
- oSB_ERROR  out  1  sticky: completion arrived for a non-pending register

## Operation
- Scoreboard: 32 GR bits + 32 sysreg bits; counter cnt, width 4.
- Source hazard: source not IMM and its scoreboard bit set and not being cleared by iLONG_DONE this cycle (completion bypassed through forwarding). A sysreg source SPR checks sysreg bit `SYSREG_SPR.
- WAW hazard: iPREV_LONG && iPREV_DEST_VALID && destination bit already set (not clearing this cycle).
- Full hazard: iPREV_LONG && cnt == P_MAX_OUTSTANDING && !iLONG_DONE_VALID.
- oPREV_BUSY = iPREV_VALID && (any hazard || iNEXT_BUSY); oNEXT_VALID = iPREV_VALID && !oPREV_BUSY && !iFLUSH.
- On issue of a long op with destination: set bit, cnt+1. On iLONG_DONE_VALID: clear bit, cnt-1. Same register set and cleared in one cycle: set wins. Issue and done same cycle: cnt unchanged.
- iLONG_DONE_VALID for a clear bit or cnt==0: no state change, oSB_ERROR set until reset.
- iFLUSH: all bits and cnt cleared next edge, overriding same-cycle set/clear; oPREV_WB_* still captured.
- Non-long instructions never touch the scoreboard.

## Timing
- oPREV_BUSY, oNEXT_VALID combinational from current inputs and state; scoreboard/cnt update on the following edge.
- oPREV_WB_* = iWB_* registered, latency 1 cycle, no gating except reset.
- Reset: scoreboard 0, cnt 0, oSB_ERROR 0, oPREV_WB_* all 0; oNEXT_VALID 0 and oPREV_BUSY 0 while iPREV_VALID is 0. Reset overrides flush and all updates.
- Input instruction fields must stay stable while oPREV_BUSY is 1.

## Configuration
- EXEC_SCHED_STALL_STAT_EN: when defined, adds output oSTALL_COUNT (32), counting cycles with oPREV_BUSY high due to a hazard (not iNEXT_BUSY), saturating at 0xFFFFFFFF, reset 0, unaffected by iFLUSH. When undefined, the port and counter are absent.

## Structure
- `SYSREG_SPR and other sysreg numbers come from core.h; P_MAX_OUTSTANDING default lives there as `EXEC_SCHED_MAX_OUTSTANDING.
- Sub-module execute_scoreboard: 64-bit bit vector + counter, set/clear/flush ports, lookup outputs; hazard logic and writeback registers stay in the top.

## Test plan
- Reset, then load to r3 (LONG) issues; next instr add r5 <- r3 -> oPREV_BUSY=1 until iLONG_DONE_DEST=3, issues in that same cycle, bit3 clear next edge.
- Src IMM with pointer 3 while r3 pending -> no stall.
- Four long ops to r1..r4 with P_MAX_OUTSTANDING=4 -> fifth long stalls; done r1 same cycle -> fifth issues, cnt stays 4.
- Long to r7 pending, new long to r7 -> WAW stall; done r7 and new issue same cycle -> bit7 remains set, cnt unchanged.
- iWB_GR_DATA=0xDEADBEEF, dest 9 at cycle N -> oPREV_WB_GR_DATA=0xDEADBEEF, dest 9 at N+1.
- Done for r12 never issued -> oSB_ERROR=1 persists; iFLUSH with pending r2 -> r2 source issues next cycle, cnt 0.

Source files
------------

// File: rtl/execute_issue_scheduler_pkg.sv
// execute_issue_scheduler_pkg
// Shared constants and types for the execute-stage issue scheduler.
//   EXEC_SCHED_MAX_OUTSTANDING : default limit on pending long-latency ops
//   SYSREG_SPR                 : system register number of the SPR
//   sb_idx_t                   : scoreboard index {sysreg, reg_num}; bit 5 selects
//                                the system-register half of the 64-bit scoreboard
//   wb_t                       : one writeback bundle (GR + SPR)
package execute_issue_scheduler_pkg;

  localparam int         EXEC_SCHED_MAX_OUTSTANDING = 4;
  localparam logic [4:0] SYSREG_SPR                 = 5'd1;

  typedef logic [5:0] sb_idx_t;

  // A sysreg source (including the SPR, number SYSREG_SPR) indexes the upper half.
  function automatic sb_idx_t sb_idx(input logic sysreg, input logic [4:0] num);
    return {sysreg, num};
  endfunction

  typedef struct packed {
    logic        gr_valid;
    logic [31:0] gr_data;
    logic [4:0]  gr_dest;
    logic        gr_dest_sysreg;
    logic        spr_valid;
    logic [31:0] spr_data;
  } wb_t;

endpackage

// File: rtl/execute_issue_scheduler_if.sv
// execute_issue_scheduler_if
// Bundle of all non-clock/reset signals of the issue scheduler.
//   slave  : the scheduler (consumes instruction, completion and writeback inputs)
//   master : dispatch / environment side
// Handshake: the instruction at the execute input is offered while iPREV_VALID is
// high; it issues in a cycle where oNEXT_VALID is high. While oPREV_BUSY is high
// the offering side must hold every iPREV_* field stable. iNEXT_BUSY from the
// downstream stage forces oPREV_BUSY and blocks issue.
interface execute_issue_scheduler_if;
  logic        iFLUSH;
  logic        iPREV_VALID;
  logic [4:0]  iPREV_SRC0_POINTER;
  logic [4:0]  iPREV_SRC1_POINTER;
  logic        iPREV_SRC0_SYSREG;
  logic        iPREV_SRC1_SYSREG;
  logic        iPREV_SRC0_IMM;
  logic        iPREV_SRC1_IMM;
  logic        iPREV_DEST_VALID;
  logic [4:0]  iPREV_DEST;
  logic        iPREV_DEST_SYSREG;
  logic        iPREV_LONG;
  logic        oPREV_BUSY;
  logic        oNEXT_VALID;
  logic        iNEXT_BUSY;
  logic        iLONG_DONE_VALID;
  logic [4:0]  iLONG_DONE_DEST;
  logic        iLONG_DONE_SYSREG;
  logic        iWB_GR_VALID;
  logic [31:0] iWB_GR_DATA;
  logic [4:0]  iWB_GR_DEST;
  logic        iWB_GR_DEST_SYSREG;
  logic        iWB_SPR_VALID;
  logic [31:0] iWB_SPR_DATA;
  logic        oPREV_WB_GR_VALID;
  logic [31:0] oPREV_WB_GR_DATA;
  logic [4:0]  oPREV_WB_GR_DEST;
  logic        oPREV_WB_GR_DEST_SYSREG;
  logic        oPREV_WB_SPR_VALID;
  logic [31:0] oPREV_WB_SPR_DATA;
  logic        oSB_ERROR;

  modport slave (
    input  iFLUSH, iPREV_VALID, iPREV_SRC0_POINTER, iPREV_SRC1_POINTER,
           iPREV_SRC0_SYSREG, iPREV_SRC1_SYSREG, iPREV_SRC0_IMM, iPREV_SRC1_IMM,
           iPREV_DEST_VALID, iPREV_DEST, iPREV_DEST_SYSREG, iPREV_LONG, iNEXT_BUSY,
           iLONG_DONE_VALID, iLONG_DONE_DEST, iLONG_DONE_SYSREG,
           iWB_GR_VALID, iWB_GR_DATA, iWB_GR_DEST, iWB_GR_DEST_SYSREG,
           iWB_SPR_VALID, iWB_SPR_DATA,
    output oPREV_BUSY, oNEXT_VALID, oPREV_WB_GR_VALID, oPREV_WB_GR_DATA,
           oPREV_WB_GR_DEST, oPREV_WB_GR_DEST_SYSREG, oPREV_WB_SPR_VALID,
           oPREV_WB_SPR_DATA, oSB_ERROR
  );

  modport master (
    output iFLUSH, iPREV_VALID, iPREV_SRC0_POINTER, iPREV_SRC1_POINTER,
           iPREV_SRC0_SYSREG, iPREV_SRC1_SYSREG, iPREV_SRC0_IMM, iPREV_SRC1_IMM,
           iPREV_DEST_VALID, iPREV_DEST, iPREV_DEST_SYSREG, iPREV_LONG, iNEXT_BUSY,
           iLONG_DONE_VALID, iLONG_DONE_DEST, iLONG_DONE_SYSREG,
           iWB_GR_VALID, iWB_GR_DATA, iWB_GR_DEST, iWB_GR_DEST_SYSREG,
           iWB_SPR_VALID, iWB_SPR_DATA,
    input  oPREV_BUSY, oNEXT_VALID, oPREV_WB_GR_VALID, oPREV_WB_GR_DATA,
           oPREV_WB_GR_DEST, oPREV_WB_GR_DEST_SYSREG, oPREV_WB_SPR_VALID,
           oPREV_WB_SPR_DATA, oSB_ERROR
  );
endinterface

// File: rtl/execute_issue_scheduler_scoreboard.sv
// execute_scoreboard
// Pending-destination bit vector (32 GR + 32 sysreg) and outstanding counter.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : clear everything on the next edge (overrides set/clr)
//   set_en / set_idx  : mark a destination pending, count +1
//   clr_en / clr_idx  : mark a destination complete, count -1
//   bits              : current pending vector, index = {sysreg, num}
//   cnt               : current number of outstanding long ops
// The caller guarantees clr_en only for a pending entry with cnt > 0.
module execute_scoreboard
  import execute_issue_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        set_en,
  input  sb_idx_t     set_idx,
  input  logic        clr_en,
  input  sb_idx_t     clr_idx,
  output logic [63:0] bits,
  output logic [3:0]  cnt
);

  logic [63:0] set_mask;
  logic [63:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bits <= '0;
      cnt  <= '0;
    end else if (flush) begin
      bits <= '0;
      cnt  <= '0;
    end else begin
      // Clear then set: a register completing and re-issued in the same cycle stays pending.
      bits <= (bits & ~clr_mask) | set_mask;
      case ({set_en, clr_en})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/execute_issue_scheduler.sv
// execute_issue_scheduler
// Decides each cycle whether the instruction at the execute input may issue,
// tracking pending long-latency destinations in execute_scoreboard, and registers
// the current writeback as the one-cycle-delayed writeback for forwarding.
//   iCLOCK       : clock
//   iRESET_SYNC  : synchronous active-high reset
//   bus          : execute_issue_scheduler_if.slave (instruction, stall/issue,
//                  completion, writeback in/out, sticky scoreboard error)
//   oSTALL_COUNT : only with EXEC_SCHED_STALL_STAT_EN defined; saturating count
//                  of cycles stalled by a hazard (not by iNEXT_BUSY)
module execute_issue_scheduler
  import execute_issue_scheduler_pkg::*;
#(
  parameter int P_MAX_OUTSTANDING = EXEC_SCHED_MAX_OUTSTANDING
) (
  input  logic iCLOCK,
  input  logic iRESET_SYNC,
  execute_issue_scheduler_if.slave bus
`ifdef EXEC_SCHED_STALL_STAT_EN
  ,
  output logic [31:0] oSTALL_COUNT
`endif
);

  logic [63:0] sb_bits;
  logic [3:0]  sb_cnt;
  sb_idx_t     src0_idx, src1_idx, dest_idx, done_idx;
  logic        done_bad, done_ok;
  logic        src0_hz, src1_hz, waw_hz, full_hz, any_hz;
  logic        issue, set_en;
  logic        sb_error;
  wb_t         wb_q;

  assign src0_idx = sb_idx(bus.iPREV_SRC0_SYSREG, bus.iPREV_SRC0_POINTER);
  assign src1_idx = sb_idx(bus.iPREV_SRC1_SYSREG, bus.iPREV_SRC1_POINTER);
  assign dest_idx = sb_idx(bus.iPREV_DEST_SYSREG, bus.iPREV_DEST);
  assign done_idx = sb_idx(bus.iLONG_DONE_SYSREG, bus.iLONG_DONE_DEST);

  // A completion for a register that is not pending (or with nothing outstanding)
  // is ignored by the scoreboard and only raises the sticky error.
  assign done_bad = bus.iLONG_DONE_VALID && (!sb_bits[done_idx] || (sb_cnt == 4'd0));
  assign done_ok  = bus.iLONG_DONE_VALID && !done_bad;

  // A completing register is forwarded this cycle, so it no longer blocks.
  assign src0_hz = !bus.iPREV_SRC0_IMM && sb_bits[src0_idx] && !(done_ok && (done_idx == src0_idx));
  assign src1_hz = !bus.iPREV_SRC1_IMM && sb_bits[src1_idx] && !(done_ok && (done_idx == src1_idx));
  assign waw_hz  = bus.iPREV_LONG && bus.iPREV_DEST_VALID && sb_bits[dest_idx]
                   && !(done_ok && (done_idx == dest_idx));
  // Only an accepted completion frees a slot; a bogus one must not let cnt overflow.
  assign full_hz = bus.iPREV_LONG && (sb_cnt == 4'(P_MAX_OUTSTANDING)) && !done_ok;
  assign any_hz  = src0_hz || src1_hz || waw_hz || full_hz;

  assign bus.oPREV_BUSY  = bus.iPREV_VALID && (any_hz || bus.iNEXT_BUSY);
  assign issue           = bus.iPREV_VALID && !bus.oPREV_BUSY && !bus.iFLUSH;
  assign bus.oNEXT_VALID = issue;
  assign set_en          = issue && bus.iPREV_LONG && bus.iPREV_DEST_VALID;

  execute_scoreboard u_sb (
    .clk     (iCLOCK),
    .rst     (iRESET_SYNC),
    .flush   (bus.iFLUSH),
    .set_en  (set_en),
    .set_idx (dest_idx),
    .clr_en  (done_ok),
    .clr_idx (done_idx),
    .bits    (sb_bits),
    .cnt     (sb_cnt)
  );

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC)   sb_error <= 1'b0;
    else if (done_bad) sb_error <= 1'b1;
  end
  assign bus.oSB_ERROR = sb_error;

  // Writeback delayed one cycle; captured regardless of flush.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wb_q <= '0;
    end else begin
      wb_q.gr_valid       <= bus.iWB_GR_VALID;
      wb_q.gr_data        <= bus.iWB_GR_DATA;
      wb_q.gr_dest        <= bus.iWB_GR_DEST;
      wb_q.gr_dest_sysreg <= bus.iWB_GR_DEST_SYSREG;
      wb_q.spr_valid      <= bus.iWB_SPR_VALID;
      wb_q.spr_data       <= bus.iWB_SPR_DATA;
    end
  end

  assign bus.oPREV_WB_GR_VALID       = wb_q.gr_valid;
  assign bus.oPREV_WB_GR_DATA        = wb_q.gr_data;
  assign bus.oPREV_WB_GR_DEST        = wb_q.gr_dest;
  assign bus.oPREV_WB_GR_DEST_SYSREG = wb_q.gr_dest_sysreg;
  assign bus.oPREV_WB_SPR_VALID      = wb_q.spr_valid;
  assign bus.oPREV_WB_SPR_DATA       = wb_q.spr_data;

`ifdef EXEC_SCHED_STALL_STAT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC)
      stall_cnt <= '0;
    else if (bus.iPREV_VALID && any_hz && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
  assign oSTALL_COUNT = stall_cnt;
`endif

endmodule
